// File: rtl/alu_decode_stage.sv
// RV32I decode stage: registers the decoded ALU/control bundle for one instruction behind a
// single-entry valid/ready slot between fetch and execute.
module alu_decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] pc_out,
  output logic [3:0]      alu_ctrl,
  output logic [1:0]      src_a_sel,
  output logic            src_b_sel,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            branch_inv,
  output logic            jump,
  output logic            illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1000;

  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // funct3 -> ALU op; alt selects SUB/SRA where funct7[5] distinguishes them
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] code;
    case (f3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      3'b111:  code = ALU_AND;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [6:0]      funct7_s;
  logic            f7_ok_s;
  logic            load_s;
  logic [31:0]     imm_i_s, imm_store_s, imm_branch_s, imm_upper_s, imm_jump_s, imm_shamt_s;
  logic [3:0]      dec_alu_s;
  logic [1:0]      dec_src_a_s;
  logic            dec_src_b_s;
  logic [31:0]     dec_imm32_s;
  logic [XLEN-1:0] dec_imm_s;
  logic            dec_rw_s, dec_mr_s, dec_mw_s, dec_br_s, dec_binv_s, dec_jump_s, dec_ill_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];
  assign f7_ok_s  = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);

  assign imm_i_s      = {{20{instr[31]}}, instr[31:20]};
  assign imm_store_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_branch_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_upper_s  = {instr[31:12], 12'h000};
  assign imm_jump_s   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_shamt_s  = {27'd0, instr[24:20]};
  assign dec_imm_s    = XLEN'($signed(dec_imm32_s));

  assign in_ready = !out_valid || out_ready;
  assign load_s   = in_valid && in_ready && !flush;

  // Combinational decode of the incoming instruction word
  always_comb begin
    dec_alu_s   = ALU_ADD;
    dec_src_a_s = SRC_A_RS1;
    dec_src_b_s = 1'b0;
    dec_imm32_s = 32'd0;
    dec_rw_s    = 1'b0;
    dec_mr_s    = 1'b0;
    dec_mw_s    = 1'b0;
    dec_br_s    = 1'b0;
    dec_binv_s  = 1'b0;
    dec_jump_s  = 1'b0;
    dec_ill_s   = 1'b0;
    case (opcode_s)
      OP_R: begin
        dec_alu_s = alu_from_f3(funct3_s, funct7_s[5]);
        dec_rw_s  = 1'b1;
        dec_ill_s = (funct3_s == 3'b011) || !f7_ok_s;
      end
      OP_I: begin
        dec_alu_s   = alu_from_f3(funct3_s, (funct3_s == 3'b101) && funct7_s[5]);
        dec_src_b_s = 1'b1;
        dec_rw_s    = 1'b1;
        dec_imm32_s = (funct3_s == 3'b001 || funct3_s == 3'b101) ? imm_shamt_s : imm_i_s;
        case (funct3_s)
          3'b011:  dec_ill_s = 1'b1;
          3'b001:  dec_ill_s = (funct7_s != F7_BASE);
          3'b101:  dec_ill_s = !f7_ok_s;
          default: dec_ill_s = 1'b0;
        endcase
      end
      OP_LOAD: begin
        dec_src_b_s = 1'b1;
        dec_imm32_s = imm_i_s;
        dec_mr_s    = 1'b1;
        dec_rw_s    = 1'b1;
      end
      OP_STORE: begin
        dec_src_b_s = 1'b1;
        dec_imm32_s = imm_store_s;
        dec_mw_s    = 1'b1;
      end
      OP_BRANCH: begin
        // compare via the ALU: SUB feeds ZF for EQ/NE, SLT result for LT/GE
        dec_imm32_s = imm_branch_s;
        dec_br_s    = 1'b1;
        case (funct3_s)
          3'b000:  begin dec_alu_s = ALU_SUB; dec_binv_s = 1'b0; end
          3'b001:  begin dec_alu_s = ALU_SUB; dec_binv_s = 1'b1; end
          3'b100:  begin dec_alu_s = ALU_SLT; dec_binv_s = 1'b1; end
          3'b101:  begin dec_alu_s = ALU_SLT; dec_binv_s = 1'b0; end
          default: dec_ill_s = 1'b1;
        endcase
      end
      OP_LUI: begin
        dec_src_a_s = SRC_A_ZERO;
        dec_src_b_s = 1'b1;
        dec_imm32_s = imm_upper_s;
        dec_rw_s    = 1'b1;
      end
      OP_AUIPC: begin
        dec_src_a_s = SRC_A_PC;
        dec_src_b_s = 1'b1;
        dec_imm32_s = imm_upper_s;
        dec_rw_s    = 1'b1;
      end
      OP_JAL: begin
        dec_src_a_s = SRC_A_PC;
        dec_src_b_s = 1'b1;
        dec_imm32_s = imm_jump_s;
        dec_jump_s  = 1'b1;
        dec_rw_s    = 1'b1;
      end
      OP_JALR: begin
        dec_src_b_s = 1'b1;
        dec_imm32_s = imm_i_s;
        dec_jump_s  = 1'b1;
        dec_rw_s    = 1'b1;
        dec_ill_s   = (funct3_s != 3'b000);
      end
      default: dec_ill_s = 1'b1;
    endcase
  end

  // Output slot: flush beats load; illegal bundles pass with side effects suppressed
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      pc_out     <= '0;
      alu_ctrl   <= 4'b0000;
      src_a_sel  <= 2'b00;
      src_b_sel  <= 1'b0;
      imm        <= '0;
      rs1        <= 5'd0;
      rs2        <= 5'd0;
      rd         <= 5'd0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      branch     <= 1'b0;
      branch_inv <= 1'b0;
      jump       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (load_s) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
      if (load_s) begin
        pc_out     <= pc_in;
        alu_ctrl   <= dec_alu_s;
        src_a_sel  <= dec_src_a_s;
        src_b_sel  <= dec_src_b_s;
        imm        <= dec_imm_s;
        rs1        <= instr[19:15];
        rs2        <= instr[24:20];
        rd         <= instr[11:7];
        reg_write  <= dec_rw_s & ~dec_ill_s;
        mem_read   <= dec_mr_s & ~dec_ill_s;
        mem_write  <= dec_mw_s & ~dec_ill_s;
        branch     <= dec_br_s & ~dec_ill_s;
        branch_inv <= dec_binv_s;
        jump       <= dec_jump_s & ~dec_ill_s;
        illegal    <= dec_ill_s;
      end else begin
        pc_out <= pc_out;
      end
    end
  end

endmodule
